// File: rtl/skinny_sbox_serial_ctrl_d3.sv
// Nibble-serial share router around the 4-share HPC2 SKINNY-64 S-box gadget:
// feeds one nibble per gadget window and reassembles the 64-bit masked output.
module skinny_sbox_serial_ctrl_d3 #(
    parameter int LATENCY = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] state_s0,
    input  logic [63:0] state_s1,
    input  logic [63:0] state_s2,
    input  logic [63:0] state_s3,
    input  logic [3:0]  SO_s0,
    input  logic [3:0]  SO_s1,
    input  logic [3:0]  SO_s2,
    input  logic [3:0]  SO_s3,
    input  logic        Synch,
    output logic [3:0]  SI_s0,
    output logic [3:0]  SI_s1,
    output logic [3:0]  SI_s2,
    output logic [3:0]  SI_s3,
    output logic        sbox_rst,
    output logic        busy,
    output logic        done,
    output logic [63:0] result_s0,
    output logic [63:0] result_s1,
    output logic [63:0] result_s2,
    output logic [63:0] result_s3
);
    localparam int GW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  idx_q;
    logic [GW-1:0] gap_q;
    logic [63:0] st_s0_q, st_s1_q, st_s2_q, st_s3_q;
    logic [63:0] res_s0_q, res_s1_q, res_s2_q, res_s3_q;
    logic [3:0]  si_s0_q, si_s1_q, si_s2_q, si_s3_q;
    logic        busy_q, done_q, sbox_rst_q;

    logic [3:0] idx_nx;
    logic [5:0] base_cur, base_nx;

    assign idx_nx   = idx_q + 4'd1;
    assign base_cur = {idx_q, 2'b00};
    assign base_nx  = {idx_nx, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            gap_q      <= '0;
            st_s0_q    <= '0;
            st_s1_q    <= '0;
            st_s2_q    <= '0;
            st_s3_q    <= '0;
            res_s0_q   <= '0;
            res_s1_q   <= '0;
            res_s2_q   <= '0;
            res_s3_q   <= '0;
            si_s0_q    <= '0;
            si_s1_q    <= '0;
            si_s2_q    <= '0;
            si_s3_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sbox_rst_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        idx_q      <= 4'd0;
                        gap_q      <= '0;
                        st_s0_q    <= state_s0;
                        st_s1_q    <= state_s1;
                        st_s2_q    <= state_s2;
                        st_s3_q    <= state_s3;
                        si_s0_q    <= state_s0[3:0];
                        si_s1_q    <= state_s1[3:0];
                        si_s2_q    <= state_s2[3:0];
                        si_s3_q    <= state_s3[3:0];
                        busy_q     <= 1'b1;
                        sbox_rst_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (Synch) begin
                        // The gadget counter must agree with LATENCY or nibbles get mixed.
                        assert (gap_q == GAP_LAST);
                        res_s0_q[base_cur +: 4] <= SO_s0;
                        res_s1_q[base_cur +: 4] <= SO_s1;
                        res_s2_q[base_cur +: 4] <= SO_s2;
                        res_s3_q[base_cur +: 4] <= SO_s3;
                        gap_q <= '0;
                        if (idx_q == 4'd15) begin
                            state_q    <= FIN;
                            done_q     <= 1'b1;
                            sbox_rst_q <= 1'b1;
                        end else begin
                            idx_q   <= idx_nx;
                            si_s0_q <= st_s0_q[base_nx +: 4];
                            si_s1_q <= st_s1_q[base_nx +: 4];
                            si_s2_q <= st_s2_q[base_nx +: 4];
                            si_s3_q <= st_s3_q[base_nx +: 4];
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    idx_q   <= 4'd0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SI_s0     = si_s0_q;
    assign SI_s1     = si_s1_q;
    assign SI_s2     = si_s2_q;
    assign SI_s3     = si_s3_q;
    assign sbox_rst  = sbox_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result_s0 = res_s0_q;
    assign result_s1 = res_s1_q;
    assign result_s2 = res_s2_q;
    assign result_s3 = res_s3_q;

endmodule

// File: tb/tb_skinny_sbox_serial_ctrl_d3.sv
// Bench for skinny_sbox_serial_ctrl_d3 with a behavioural 4-share S-box gadget
// that strobes Synch every L cycles and re-shares its output randomly.
module tb_skinny_sbox_serial_ctrl_d3;
    localparam int L = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] state_s0, state_s1, state_s2, state_s3;
    logic [3:0]  so_s0, so_s1, so_s2, so_s3;
    logic        synch;
    logic [3:0]  si_s0, si_s1, si_s2, si_s3;
    logic        sbox_rst, busy, done;
    logic [63:0] result_s0, result_s1, result_s2, result_s3;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    skinny_sbox_serial_ctrl_d3 #(.LATENCY(L)) dut (
        .clk(clk), .rst(rst), .start(start),
        .state_s0(state_s0), .state_s1(state_s1), .state_s2(state_s2), .state_s3(state_s3),
        .SO_s0(so_s0), .SO_s1(so_s1), .SO_s2(so_s2), .SO_s3(so_s3),
        .Synch(synch),
        .SI_s0(si_s0), .SI_s1(si_s1), .SI_s2(si_s2), .SI_s3(si_s3),
        .sbox_rst(sbox_rst), .busy(busy), .done(done),
        .result_s0(result_s0), .result_s1(result_s1), .result_s2(result_s2), .result_s3(result_s3)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hc;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
            4'h4: return 4'h1;  4'h5: return 4'ha;  4'h6: return 4'h2;  4'h7: return 4'hb;
            4'h8: return 4'h3;  4'h9: return 4'h8;  4'ha: return 4'h5;  4'hb: return 4'hd;
            4'hc: return 4'h4;  4'hd: return 4'he;  4'he: return 4'h7;  default: return 4'hf;
        endcase
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] p);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox4(p[4*i +: 4]);
        return r;
    endfunction

    // Behavioural gadget: counter held in reset by sbox_rst, Synch on the last window cycle.
    int   gcnt = 0;
    logic reshare_en = 1'b0;
    logic force_en = 1'b0, force_synch = 1'b0;
    logic [3:0] f0 = '0, f1 = '0, f2 = '0, f3 = '0;
    logic [3:0] m1 = '0, m2 = '0, m3 = '0;
    logic [3:0] x_in;

    always @(posedge clk) begin
        if (sbox_rst) gcnt <= 0;
        else gcnt <= (gcnt == L-1) ? 0 : gcnt + 1;
    end

    always @(negedge clk) begin
        if (reshare_en) begin
            m1 = 4'($urandom); m2 = 4'($urandom); m3 = 4'($urandom);
        end else begin
            m1 = '0; m2 = '0; m3 = '0;
        end
    end

    assign x_in  = si_s0 ^ si_s1 ^ si_s2 ^ si_s3;
    assign synch = (!sbox_rst && gcnt == L-1) || force_synch;
    assign so_s0 = force_en ? f0 : (sbox4(x_in) ^ m1 ^ m2 ^ m3);
    assign so_s1 = force_en ? f1 : m1;
    assign so_s2 = force_en ? f2 : m2;
    assign so_s3 = force_en ? f3 : m3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after the start sampling edge; follows one operation to its done cycle.
    task automatic track_op(input logic [63:0] s0, input logic [63:0] s1, input logic [63:0] s2,
                            input logic [63:0] s3, input bit full_shares, input bit mid_change);
        int low_cnt = 0, cap = 0, done_n = -1;
        bit si_ok = 1'b1, si_stable = 1'b1;
        logic [15:0] cur_si, prev_si = '0, exp_si;
        logic prev_synch = 1'b0;
        logic [63:0] exp;
        exp = exp_q.pop_front();
        for (int n = 1; n <= 16*L + 20 && done_n < 0; n++) begin
            @(negedge clk);
            if (mid_change && n == 60) begin
                state_s0 = {$urandom, $urandom}; state_s1 = {$urandom, $urandom};
                state_s2 = {$urandom, $urandom}; state_s3 = {$urandom, $urandom};
            end
            if (sbox_rst === 1'b0) low_cnt++;
            cur_si = {si_s3, si_s2, si_s1, si_s0};
            if (done === 1'b1) begin
                done_n = n;
            end else begin
                if (n >= 2 && cur_si !== prev_si && !prev_synch) si_stable = 1'b0;
                if (cap < 16) begin
                    exp_si = {s3[4*cap +: 4], s2[4*cap +: 4], s1[4*cap +: 4], s0[4*cap +: 4]};
                    if (cur_si !== exp_si || busy !== 1'b1) si_ok = 1'b0;
                end
                if (synch) cap++;
            end
            prev_si = cur_si;
            prev_synch = synch;
        end
        chk("done_seen", {63'd0, done_n > 0}, 64'd1);
        chk("done_latency", 64'(done_n - 1), 64'(16*L));
        chk("busy_in_done", {63'd0, busy}, 64'd1);
        chk("captures", 64'(cap), 64'd16);
        chk("sbox_rst_low_cycles", 64'(low_cnt), 64'(16*L));
        chk("si_nibble_order", {63'd0, si_ok}, 64'd1);
        chk("si_stable", {63'd0, si_stable}, 64'd1);
        chk("result_xor", result_s0 ^ result_s1 ^ result_s2 ^ result_s3, exp);
        if (full_shares) begin
            chk("result_s0", result_s0, exp);
            chk("result_s1", result_s1, 64'd0);
            chk("result_s2", result_s2, 64'd0);
            chk("result_s3", result_s3, 64'd0);
        end
    endtask

    task automatic run_op(input logic [63:0] s0, input logic [63:0] s1, input logic [63:0] s2,
                          input logic [63:0] s3, input logic [63:0] exp, input bit full_shares,
                          input bit hold, input bit mid_change);
        @(negedge clk);
        state_s0 = s0; state_s1 = s1; state_s2 = s2; state_s3 = s3;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        track_op(s0, s1, s2, s3, full_shares, mid_change);
        @(negedge clk);
        chk("busy_after_fin", {63'd0, busy}, 64'd0);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    typedef struct {
        logic [63:0] plain;
        logic [63:0] exp;
        bit          shared;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [63:0] a1, a2, a3, p, c0, c1, c2, c3;
        bit idle_ok;

        tbl[0] = '{64'hFEDCBA9876543210, 64'hF7E4D583B2A1096C, 1'b0};
        tbl[1] = '{64'hFEDCBA9876543210, 64'hF7E4D583B2A1096C, 1'b1};
        tbl[2] = '{64'h0000000000000000, 64'hCCCCCCCCCCCCCCCC, 1'b1};
        tbl[3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1};
        tbl[4] = '{64'h0123456789ABCDEF, 64'hC6901A2B385D4E7F, 1'b0};

        rst = 1'b1; start = 1'b0;
        state_s0 = '0; state_s1 = '0; state_s2 = '0; state_s3 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_sbox_rst", {63'd0, sbox_rst}, 64'd1);
        chk("reset_si", {48'd0, si_s3, si_s2, si_s1, si_s0}, 64'd0);
        chk("reset_result", result_s0 | result_s1 | result_s2 | result_s3, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            reshare_en = tbl[i].shared;
            if (tbl[i].shared) begin
                a1 = {$urandom, $urandom}; a2 = {$urandom, $urandom}; a3 = {$urandom, $urandom};
            end else begin
                a1 = '0; a2 = '0; a3 = '0;
            end
            run_op(tbl[i].plain ^ a1 ^ a2 ^ a3, a1, a2, a3, tbl[i].exp, !tbl[i].shared, 1'b0, 1'b0);
        end

        // Spurious Synch in IDLE with changing SO must leave the last result intact.
        idle_ok = 1'b1;
        force_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            f0 = 4'($urandom); f1 = 4'($urandom); f2 = 4'($urandom); f3 = 4'($urandom);
            force_synch = 1'b1;
            if (busy !== 1'b0) idle_ok = 1'b0;
        end
        @(negedge clk);
        force_synch = 1'b0; force_en = 1'b0;
        @(negedge clk);
        chk("idle_synch_busy", {63'd0, idle_ok && busy === 1'b0}, 64'd1);
        chk("idle_synch_r0", result_s0, 64'hC6901A2B385D4E7F);
        chk("idle_synch_r123", result_s1 | result_s2 | result_s3, 64'd0);

        reshare_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p  = {$urandom, $urandom};
            a1 = {$urandom, $urandom}; a2 = {$urandom, $urandom}; a3 = {$urandom, $urandom};
            run_op(p ^ a1 ^ a2 ^ a3, a1, a2, a3, sbox_layer(p), 1'b0, 1'b0, 1'b0);
        end

        // start held high through a run, inputs changed mid-run, then a back-to-back run.
        p  = {$urandom, $urandom};
        a1 = {$urandom, $urandom}; a2 = {$urandom, $urandom}; a3 = {$urandom, $urandom};
        run_op(p ^ a1 ^ a2 ^ a3, a1, a2, a3, sbox_layer(p), 1'b0, 1'b1, 1'b1);
        c0 = state_s0; c1 = state_s1; c2 = state_s2; c3 = state_s3;
        exp_q.push_back(sbox_layer(c0 ^ c1 ^ c2 ^ c3));
        @(posedge clk);
        #1;
        start = 1'b0;
        track_op(c0, c1, c2, c3, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_busy_after_fin", {63'd0, busy}, 64'd0);

        // Asynchronous reset at cycle 60 of a run.
        @(negedge clk);
        state_s0 = {$urandom, $urandom}; state_s1 = {$urandom, $urandom};
        state_s2 = {$urandom, $urandom}; state_s3 = {$urandom, $urandom};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (59) @(negedge clk);
        chk("abort_running", {63'd0, busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_sbox_rst", {63'd0, sbox_rst}, 64'd1);
        chk("abort_si", {48'd0, si_s3, si_s2, si_s1, si_s0}, 64'd0);
        chk("abort_result", result_s0 | result_s1 | result_s2 | result_s3, 64'd0);
        idle_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || sbox_rst !== 1'b1) idle_ok = 1'b0;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("abort_no_done", {63'd0, idle_ok}, 64'd1);
        p  = {$urandom, $urandom};
        a1 = {$urandom, $urandom}; a2 = {$urandom, $urandom}; a3 = {$urandom, $urandom};
        run_op(p ^ a1 ^ a2 ^ a3, a1, a2, a3, sbox_layer(p), 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
